// File: rtl/alu_share_arb_pkg.sv
// Shared encodings for the two-requester add/sub/SLT sequencer.
package alu_share_arb_pkg;

  localparam int unsigned DEF_WIDTH = 10;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SLT = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

  function automatic logic op_is_sub(input op_e op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_share_arb_rr_pick2.sv
// Combinational 2-way round-robin pick: on a tie the requester not granted last wins.
module alu_share_arb_rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_id
);

  always_comb begin
    grant    = '0;
    grant_id = 1'b0;
    unique case (valid)
      2'b01: begin
        grant    = 2'b01;
        grant_id = 1'b0;
      end
      2'b10: begin
        grant    = 2'b10;
        grant_id = 1'b1;
      end
      2'b11: begin
        grant_id = ~last_grant;
        grant    = last_grant ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one add/sub/SLT unit between two requesters: IDLE -> EXEC -> RESP.
// Optional grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N_REQ = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_subtract,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_carryout,
  input  logic             alu_overflow,
  input  logic             alu_slt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carryout,
  output logic             rsp_overflow,
  output logic             rsp_err,
  output logic             busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_sub_q, alu_sub_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_co_q, rsp_co_d;
  logic             rsp_ov_q, rsp_ov_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;

  logic [1:0]       pick;
  logic             pick_id;
  op_e              sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;

  alu_share_arb_rr_pick2 u_pick (
    .valid      (req_valid),
    .last_grant (last_q),
    .grant      (pick),
    .grant_id   (pick_id)
  );

  assign req_ready = (state_q == S_IDLE) ? pick : '0;

  assign sel_op = pick_id ? op_e'(req_op1) : op_e'(req_op0);
  assign sel_a  = pick_id ? req_a1 : req_a0;
  assign sel_b  = pick_id ? req_b1 : req_b0;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    last_d       = last_q;
    id_d         = id_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sub_d    = alu_sub_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_co_d     = rsp_co_q;
    rsp_ov_d     = rsp_ov_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (|pick) begin
          op_d    = sel_op;
          id_d    = pick_id;
          last_d  = pick_id;
          state_d = S_EXEC;
          // Reserved op keeps the shared unit quiet.
          if (sel_op == OP_RSV) begin
            alu_a_d   = '0;
            alu_b_d   = '0;
            alu_sub_d = 1'b0;
          end else begin
            alu_a_d   = sel_a;
            alu_b_d   = sel_b;
            alu_sub_d = op_is_sub(sel_op);
          end
        end
      end
      S_EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_err_d   = 1'b0;
        state_d     = S_RESP;
        unique case (op_q)
          OP_ADD, OP_SUB: begin
            rsp_result_d = alu_sum;
            rsp_co_d     = alu_carryout;
            rsp_ov_d     = alu_overflow;
          end
          OP_SLT: begin
            rsp_result_d    = '0;
            rsp_result_d[0] = alu_slt;
            rsp_co_d        = 1'b0;
            rsp_ov_d        = 1'b0;
          end
          default: begin
            rsp_result_d = '0;
            rsp_co_d     = 1'b0;
            rsp_ov_d     = 1'b0;
            rsp_err_d    = 1'b1;
          end
        endcase
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_ADD;
      last_q       <= 1'b1;
      id_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sub_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_co_q     <= 1'b0;
      rsp_ov_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      last_q       <= last_d;
      id_q         <= id_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sub_q    <= alu_sub_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_co_q     <= rsp_co_d;
      rsp_ov_q     <= rsp_ov_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_subtract = alu_sub_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carryout = rsp_co_q;
  assign rsp_overflow = rsp_ov_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = busy_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (req_ready[0] && (cnt0_q != '1)) cnt0_d = cnt0_q + 16'd1;
    if (req_ready[1] && (cnt1_q != '1)) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: vector table, hand-written corner sequences, randomized traffic vs. a reference model.
module tb_alu_share_arb;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_ready;
  logic [1:0]   req_op0, req_op1;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [W-1:0] alu_a, alu_b, alu_sum;
  logic         alu_subtract, alu_carryout, alu_overflow, alu_slt;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_result;
  logic         rsp_carryout, rsp_overflow, rsp_err, busy;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]  grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  alu_share_arb #(.WIDTH(W), .N_REQ(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_subtract(alu_subtract),
    .alu_sum(alu_sum), .alu_carryout(alu_carryout),
    .alu_overflow(alu_overflow), .alu_slt(alu_slt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carryout(rsp_carryout),
    .rsp_overflow(rsp_overflow), .rsp_err(rsp_err), .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Shared adder/subtractor as seen by the arbiter.
  logic [W-1:0] bx;
  logic [W:0]   full;
  assign bx           = alu_b ^ {W{alu_subtract}};
  assign full         = {1'b0, alu_a} + {1'b0, bx} + {{W{1'b0}}, alu_subtract};
  assign alu_sum      = full[W-1:0];
  assign alu_carryout = full[W];
  assign alu_overflow = (alu_a[W-1] == bx[W-1]) && (alu_sum[W-1] != alu_a[W-1]);
  assign alu_slt      = alu_sum[W-1] ^ alu_overflow;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] result;
    logic         co;
    logic         ov;
    logic         err;
  } rsp_t;

  function automatic int sval(input logic [W-1:0] x);
    return x[W-1] ? int'(x) - (1 << W) : int'(x);
  endfunction

  function automatic logic in_range(input int v);
    return (v <= (1 << (W-1)) - 1) && (v >= -(1 << (W-1)));
  endfunction

  function automatic rsp_t ref_rsp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    rsp_t r;
    int   s;
    r = '0;
    case (op)
      2'd0: begin
        s        = int'(a) + int'(b);
        r.result = s[W-1:0];
        r.co     = (s >= (1 << W));
        r.ov     = !in_range(sval(a) + sval(b));
      end
      2'd1: begin
        s        = int'(a) - int'(b);
        r.result = s[W-1:0];
        r.co     = (int'(a) >= int'(b));
        r.ov     = !in_range(sval(a) - sval(b));
      end
      2'd2: r.result = (sval(a) < sval(b)) ? 1 : 0;
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 10'h1FF;
      2: return 10'h200;
      3: return 10'h3FF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic set_req(input int id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
    else         begin req_op1 = op; req_a1 = a; req_b1 = b; end
    req_valid[id] = 1'b1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Single request; latency counts cycles from the handshake cycle to first rsp_valid.
  task automatic run_one(input int id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic ok, output int lat, output logic [2*W:0] snap,
                         output logic rid, output rsp_t r);
    ok = 1'b0; lat = 0; snap = '0; rid = 1'b0; r = '0;
    rsp_ready = 1'b1;
    set_req(id, op, a, b);
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = '0;
    if (!ok) return;
    ok = 1'b0;
    @(negedge clk);
    snap = {alu_a, alu_b, alu_subtract};
    lat  = 1;
    for (int k = 0; k < 10 && !ok; k++) begin
      if (rsp_valid) begin
        ok       = 1'b1;
        rid      = rsp_id;
        r.result = rsp_result;
        r.co     = rsp_carryout;
        r.ov     = rsp_overflow;
        r.err    = rsp_err;
      end else begin
        @(posedge clk); #1;
        @(negedge clk);
        lat++;
      end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    int           id;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         err;
  } vec_t;

  vec_t vt[9];

`ifdef ALU_ARB_STATS_EN
  logic [15:0] m_cnt0, m_cnt1;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt0 <= '0;
      m_cnt1 <= '0;
    end else begin
      if (req_valid[0] && req_ready[0]) m_cnt0 <= m_cnt0 + 16'd1;
      if (req_valid[1] && req_ready[1]) m_cnt1 <= m_cnt1 + 16'd1;
    end
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic         ok, rid, outstanding, exp_last, gid, exp_id, exp_rv, hit;
    logic [1:0]   exp_rdy, taken;
    logic [2*W:0] snap, exp_snap;
    rsp_t         r, exp_r;
    int           lat, acc_cyc, n_done, n_rsp;
    logic [1:0]   alt_ids[4];
    logic [W-1:0] alt_res[4];

    vt[0] = '{0, 2'b01, 10'h000, 10'h1FF, 10'h201, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1, 2'b00, 10'h1FF, 10'h001, 10'h200, 1'b0, 1'b1, 1'b0};
    vt[2] = '{0, 2'b11, 10'h155, 10'h0AA, 10'h000, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1, 2'b10, 10'h000, 10'h1FF, 10'h001, 1'b0, 1'b0, 1'b0};
    vt[4] = '{0, 2'b10, 10'h200, 10'h000, 10'h001, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1, 2'b10, 10'h1FF, 10'h200, 10'h000, 1'b0, 1'b0, 1'b0};
    vt[6] = '{0, 2'b00, 10'h3FF, 10'h001, 10'h000, 1'b1, 1'b0, 1'b0};
    vt[7] = '{1, 2'b01, 10'h200, 10'h001, 10'h1FF, 1'b1, 1'b1, 1'b0};
    vt[8] = '{0, 2'b01, 10'h005, 10'h003, 10'h002, 1'b1, 1'b0, 1'b0};

    reset = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_op0 = '0; req_op1 = '0; req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    #1 reset = 1'b1;

    @(negedge clk);
    chk("rst_rsp_flags", {rsp_valid, rsp_id, rsp_carryout, rsp_overflow, rsp_err}, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_alu", {alu_a, alu_b, alu_subtract}, 0);
    chk("rst_busy_ready", {busy, req_ready}, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_one(vt[i].id, vt[i].op, vt[i].a, vt[i].b, ok, lat, snap, rid, r);
      chk($sformatf("vec%0d_done", i), ok, 1);
      chk($sformatf("vec%0d_latency", i), lat, 2);
      chk($sformatf("vec%0d_id", i), rid, vt[i].id[0]);
      chk($sformatf("vec%0d_result", i), r.result, vt[i].res);
      chk($sformatf("vec%0d_co_ov_err", i), {r.co, r.ov, r.err}, {vt[i].co, vt[i].ov, vt[i].err});
      exp_snap = (vt[i].op == 2'b11) ? '0 : {vt[i].a, vt[i].b, vt[i].op != 2'b00};
      chk($sformatf("vec%0d_alu_drive", i), snap, exp_snap);
    end

    // Both requesters always valid: grants alternate starting at requester 0.
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 2'b10, 10'h000, 10'h1FF);
    set_req(1, 2'b10, 10'h000, 10'h1FF);
    n_rsp = 0;
    for (int k = 0; k < 20 && n_rsp < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        alt_ids[n_rsp] = {1'b0, rsp_id};
        alt_res[n_rsp] = rsp_result;
        n_rsp++;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    chk("alt_count", n_rsp, 4);
    for (int i = 0; i < n_rsp; i++) begin
      chk($sformatf("alt%0d_id", i), alt_ids[i], i % 2);
      chk($sformatf("alt%0d_result", i), alt_res[i], 1);
    end

    // Consumer stalls in RESP: response held, no new grant until taken.
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 2'b00, 10'h0F0, 10'h00F);
    set_req(1, 2'b01, 10'h001, 10'h001);
    @(negedge clk);
    chk("stall_grant0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("stall_exec", {req_ready, rsp_valid, busy}, 4'b0001);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid_rdy", k), {rsp_valid, req_ready}, 3'b100);
      chk($sformatf("stall%0d_rsp", k), {rsp_id, rsp_result, rsp_carryout, rsp_overflow, rsp_err},
          {1'b0, 10'h0FF, 3'b000});
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_take_valid", rsp_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_rsp_drop", rsp_valid, 0);
    chk("stall_next_grant", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = '0;

    // Reset during EXEC after a grant to requester 0.
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 2'b00, 10'h1FF, 10'h001);
    @(negedge clk);
    chk("rmid_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    #1 reset = 1'b1;
    #1;
    chk("rmid_alu", {alu_a, alu_b, alu_subtract}, 0);
    chk("rmid_rsp", {rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_overflow, rsp_err, busy}, 0);
    @(negedge clk); reset = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (rsp_valid || busy) hit = 1'b1;
    end
    chk("rmid_no_rsp", hit, 0);
    @(posedge clk); #1;
    set_req(0, 2'b00, 10'h001, 10'h001);
    set_req(1, 2'b00, 10'h002, 10'h002);
    @(negedge clk);
    chk("rmid_tie_to_0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;

    // Randomized traffic against the arbitration/result rules.
    do_reset();
    outstanding = 1'b0; exp_last = 1'b1; exp_id = 1'b0; exp_r = '0;
    acc_cyc = 0; n_done = 0; taken = '0;
    for (int c = 0; c < 400; c++) begin
      for (int q = 0; q < 2; q++) begin
        if (taken[q]) begin
          req_valid[q] = 1'b0;
          taken[q]     = 1'b0;
        end
        if (!req_valid[q]) begin
          if ($urandom_range(0, 2) != 0)
            set_req(q, 2'($urandom_range(0, 3)), rand_opnd(), rand_opnd());
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[q] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_rdy = '0;
      gid     = 1'b0;
      if (!outstanding && (req_valid != 2'b00)) begin
        gid = (req_valid == 2'b11) ? !exp_last : req_valid[1];
        exp_rdy[gid] = 1'b1;
      end
      chk("rnd_ready", req_ready, exp_rdy);
      chk("rnd_busy", busy, outstanding);
      exp_rv = outstanding && (cyc - acc_cyc >= 2);
      chk("rnd_rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
        chk("rnd_rsp_id", rsp_id, exp_id);
        chk("rnd_rsp_result", rsp_result, exp_r.result);
        chk("rnd_rsp_flags", {rsp_carryout, rsp_overflow, rsp_err}, {exp_r.co, exp_r.ov, exp_r.err});
        if (rsp_ready) begin
          outstanding = 1'b0;
          n_done++;
        end
      end
      if (exp_rdy != 2'b00) begin
        outstanding = 1'b1;
        acc_cyc     = cyc;
        exp_last    = gid;
        exp_id      = gid;
        exp_r       = gid ? ref_rsp(req_op1, req_a1, req_b1) : ref_rsp(req_op0, req_a0, req_b0);
        taken[gid]  = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    chk("rnd_progress", n_done > 20, 1);

`ifdef ALU_ARB_STATS_EN
    chk("stats_cnt0", grant_cnt0, m_cnt0);
    chk("stats_cnt1", grant_cnt1, m_cnt1);
    chk("stats_nonzero", (grant_cnt0 != 0) && (grant_cnt1 != 0), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
